multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Sequences the RV32I multi-cycle datapath through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
// - Drives PC/IR/regfile/memory enables, ALU operand and op selects, and a 2-cycle-cheap memory req/ready handshake.
// - Decodes the opcode set R_TYPE/LW/SW/BR/IMM/JAL/JALR; anything else traps. Sits beside the datapath.
// PARAMETERS
// - MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready before trap; 0 = no timeout
// PORTS
// - clk           in   1  clock, all state updates on rising edge
// - reset         in   1  synchronous, active-high
// - opcode        in   7  instr[6:0] from IR; sampled in DECODE
// - mem_ready     in   1  memory completed current req (read data valid / write done)
// - branch_taken  in   1  datapath branch-compare result, valid in EXEC of BR
// - ir_write      out  1  latch fetched word into IR, PC into OldPC
// - pc_write      out  1  update PC with source pc_src
// - pc_src        out  2  00 ALU result, 01 ALUOut reg, 10 ALU result & ~1
// - mem_req       out  1  memory request, held until mem_ready
// - mem_we        out  1  write request (valid with mem_req)
// - mem_addr_sel  out  1  0 PC, 1 ALUOut
// - alu_src_a     out  2  00 PC, 01 OldPC, 10 rs1
// - alu_src_b     out  2  00 rs2, 01 imm, 10 const 4
// - alu_op        out  2  00 add, 01 branch compare, 10 funct-decoded, 11 add (jump)
// - reg_write     out  1  regfile write enable
// - wb_sel        out  2  00 ALUOut, 01 MDR, 10 PC
// - instr_retire  out  1  1-cycle pulse on last cycle of each completed instruction
// - trap          out  1  sticky; FSM in TRAP
// - trap_cause    out  2  00 none, 01 illegal opcode, 10 memory timeout
// BEHAVIOUR
// - Outputs combinational from state, opcode_q, mem_ready, branch_taken; all default 0 unless listed.
// - While reset=1: all outputs 0 that cycle; next edge state=FETCH, opcode_q=0, wait_cnt=0, trap_cause=00.
// - Reset mid-instruction or mid-handshake: mem_req drops same cycle; no partial write; restart at FETCH.
// - FETCH: mem_req=1, addr_sel=0, a=PC, b=4, alu_op=00. On mem_ready: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
// - DECODE: opcode_q<=opcode; a=OldPC, b=imm, alu_op=00 (target into ALUOut). Unknown opcode -> TRAP cause 01; else EXEC.
// - EXEC R_TYPE: a=rs1, b=rs2, op=10 -> WB.  IMM: a=rs1, b=imm, op=10 -> WB.  LW/SW: a=rs1, b=imm, op=00 -> MEM.
// - EXEC BR: a=rs1, b=rs2, op=01; pc_write=branch_taken, pc_src=01; retire -> FETCH.
// - EXEC JAL: reg_write=1, wb_sel=10 (PC already +4), pc_write=1, pc_src=01; retire -> FETCH.
// - EXEC JALR: a=rs1, b=imm, op=11; reg_write=1, wb_sel=10, pc_write=1, pc_src=10; retire -> FETCH.
// - MEM: mem_req=1, addr_sel=1, mem_we=(SW). On mem_ready: LW -> WB; SW retire -> FETCH.
// - WB: reg_write=1, wb_sel=01 if LW else 00; retire -> FETCH.
// - TRAP: all enables and mem_req 0, trap=1, trap_cause held; leaves only on reset.
// - wait_cnt: clears on entering FETCH/MEM and on mem_ready; +1 each cycle mem_req=1 & !mem_ready;
//   if MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT-1 with mem_ready still 0 -> TRAP cause 10 next edge.
//   mem_ready on the limit cycle wins over timeout. Counter width clog2(MEM_TIMEOUT+1), saturates, never wraps.
// - Zero-wait latency (cycles): R/IMM 4, LW 5, SW 4, BR 3, JAL 3, JALR 3; each wait cycle adds 1.
// - opcode is ignored outside DECODE; branch_taken ignored outside EXEC of BR; mem_ready ignored when mem_req=0.
// TESTING
// - R_TYPE 0x33, mem_ready always 1 -> 4 cycles, reg_write only in WB with wb_sel=00, one retire pulse.
// - LW 0x03, fetch ready after 2 waits, MEM ready immediately -> 7 cycles, WB wb_sel=01, mem_we never 1.
// - BR 0x63 taken=1 then taken=0 -> pc_write at EXEC with pc_src=01 only when taken; 3 cycles each.
// - JALR 0x67 -> EXEC asserts reg_write, wb_sel=10, pc_write, pc_src=10 in the same cycle; retire.
// - Opcode 0x7F -> TRAP after DECODE, trap_cause=01, all enables 0 for 20 cycles; reset returns FETCH.
// - MEM_TIMEOUT=4, SW with mem_ready held 0 in MEM -> TRAP cause 10 after 4 req cycles; ready on 4th -> no trap.
// - Reset asserted during MEM with mem_req=1 -> mem_req=0 same cycle, FETCH next, no mem_we seen.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multi-cycle RV32I datapath. Steps one instruction at a
// time through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath enables and
// muxes, and runs a req/ready memory handshake with an optional timeout.
// An illegal opcode or a memory timeout parks the FSM in TRAP until reset.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // Wait counter is wide enough to hold MEM_TIMEOUT. It is kept at least 1 bit
    // wide so that the timeout-disabled case still elaborates.
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit TMO_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic             opcode_legal;
    logic             timeout_now;

    // The opcode classification is done on the live IR opcode during DECODE.
    always_comb begin
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR: opcode_legal = 1'b1;
            default:                                           opcode_legal = 1'b0;
        endcase
    end

    // The last allowed unanswered request cycle. If mem_ready is still low, the
    // FSM traps on the next edge. If ready arrives in that cycle, it wins.
    assign timeout_now = TMO_EN && (wait_cnt_q == TMO_LIMIT);

    // Next-state logic, plus datapath controls decoded from the state and the latched opcode.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = wait_cnt_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        instr_retire = 1'b0;
        trap         = 1'b0;
        trap_cause   = 2'b00;

        case (state_q)
            S_FETCH: begin
                // Fetch from the PC. In the same cycle, the ALU computes PC+4.
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_now) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                // Compute the branch/jump target OldPC+imm into ALUOut, whatever the opcode is.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                opcode_d  = opcode;
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        alu_src_a = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_IMM: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a    = 2'b10;
                        alu_op       = 2'b01;
                        pc_write     = branch_taken;
                        pc_src       = 2'b01;
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_JAL: begin
                        // The PC already holds the link value (+4), and ALUOut holds the target.
                        reg_write    = 1'b1;
                        wb_sel       = 2'b10;
                        pc_write     = 1'b1;
                        pc_src       = 2'b01;
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src_a    = 2'b10;
                        alu_src_b    = 2'b01;
                        alu_op       = 2'b11;
                        reg_write    = 1'b1;
                        wb_sel       = 2'b10;
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        // Not reachable, because DECODE filters opcodes. Treat it as illegal anyway.
                        state_d      = S_TRAP;
                        trap_cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode_q == OP_SW);
                if (mem_ready) begin
                    if (opcode_q == OP_SW) begin
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_now) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                wb_sel       = (opcode_q == OP_LW) ? 2'b01 : 2'b00;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = trap_cause_q;
            end
            default: state_d = S_FETCH;
        endcase

        // The wait counter is only meaningful while a request is outstanding.
        // It restarts on every new request and on every completion.
        if (!mem_req || mem_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        // Reset overrides everything combinationally, so an in-flight request or write drops at once.
        if (reset) begin
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 2'b00;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            alu_src_a    = 2'b00;
            alu_src_b    = 2'b00;
            alu_op       = 2'b00;
            reg_write    = 1'b0;
            wb_sel       = 2'b00;
            instr_retire = 1'b0;
            trap         = 1'b0;
            trap_cause   = 2'b00;
        end
    end

    // State, latched opcode, wait counter and trap cause, all with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            opcode_q     <= 7'h00;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm (MEM_TIMEOUT=4). Each instruction is
// expanded into a per-cycle phase schedule: fetch waits, the fixed steps for
// the opcode class, and memory waits. Expected outputs come from a table of
// control values indexed by phase. Inputs that the design must ignore are randomized.
module tb_multicycle_control_fsm;

    localparam int TMO = 4;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    localparam int P_F = 0;
    localparam int P_D = 1;
    localparam int P_E = 2;
    localparam int P_M = 3;
    localparam int P_W = 4;
    localparam int P_T = 5;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_retire;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       ir_write, pc_write, mem_req, mem_we, mem_addr_sel, reg_write;
    logic       instr_retire, trap;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
    outs_t      got;

    int n_checks = 0;
    int n_fail = 0;
    int retire_seen = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .instr_retire(instr_retire), .trap(trap), .trap_cause(trap_cause)
    );

    assign got = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                  instr_retire, trap, trap_cause};

    function automatic bit is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR) ||
               (op == OP_IMM) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Control values the datapath needs in each phase of an instruction.
    function automatic outs_t exp_out(input int ph, input logic [6:0] op, input logic rdy,
                                      input logic tk, input logic [1:0] cause);
        outs_t e;
        e = '0;
        case (ph)
            P_F: begin
                e.mem_req   = 1'b1;
                e.alu_src_b = 2'b10;
                e.ir_write  = rdy;
                e.pc_write  = rdy;
            end
            P_D: begin
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b01;
            end
            P_E: begin
                if (op == OP_R) begin
                    e.alu_src_a = 2'b10; e.alu_op = 2'b10;
                end else if (op == OP_IMM) begin
                    e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10;
                end else if (op == OP_LW || op == OP_SW) begin
                    e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                end else if (op == OP_BR) begin
                    e.alu_src_a = 2'b10; e.alu_op = 2'b01;
                    e.pc_write = tk; e.pc_src = 2'b01; e.instr_retire = 1'b1;
                end else if (op == OP_JAL) begin
                    e.reg_write = 1'b1; e.wb_sel = 2'b10;
                    e.pc_write = 1'b1; e.pc_src = 2'b01; e.instr_retire = 1'b1;
                end else if (op == OP_JALR) begin
                    e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b11;
                    e.reg_write = 1'b1; e.wb_sel = 2'b10;
                    e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_retire = 1'b1;
                end
            end
            P_M: begin
                e.mem_req      = 1'b1;
                e.mem_addr_sel = 1'b1;
                e.mem_we       = (op == OP_SW);
                e.instr_retire = rdy && (op == OP_SW);
            end
            P_W: begin
                e.reg_write    = 1'b1;
                e.wb_sel       = (op == OP_LW) ? 2'b01 : 2'b00;
                e.instr_retire = 1'b1;
            end
            P_T: begin
                e.trap       = 1'b1;
                e.trap_cause = cause;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One clock cycle: drive the inputs at the falling edge, then check the outputs 1 time unit later.
    task automatic step(input logic rst, input logic rdy, input logic tk,
                        input logic [6:0] op, input outs_t exp, input string nm);
        @(negedge clk);
        reset = rst; mem_ready = rdy; branch_taken = tk; opcode = op;
        #1;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %h expected %h", nm, got, exp);
        end
        if (got.instr_retire === 1'b1) retire_seen++;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    // A handshake phase with w unanswered cycles. After TMO unanswered cycles, the model expects a trap.
    task automatic hs_phase(input int ph, input logic [6:0] op, input int w,
                            input string nm, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < w; i++) begin
            step(1'b0, 1'b0, rbit(), rop(), exp_out(ph, op, 1'b0, 1'b0, 2'b00), nm);
            if (i + 1 == TMO) begin
                timed_out = 1'b1;
                return;
            end
        end
        step(1'b0, 1'b1, rbit(), rop(), exp_out(ph, op, 1'b1, 1'b0, 2'b00), nm);
    endtask

    task automatic trap_phase(input logic [1:0] cause, input int n, input string nm);
        for (int i = 0; i < n; i++)
            step(1'b0, rbit(), rbit(), rop(), exp_out(P_T, 7'h00, 1'b0, 1'b0, cause), nm);
    endtask

    // Reset held for two cycles: all outputs are 0 while reset is high, whatever the inputs.
    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            step(1'b1, rbit(), rbit(), rop(), '0, "reset_outputs");
        $display("reset applied");
    endtask

    // One complete instruction: fetch, decode, exec, then optional mem and wb.
    task automatic test_instr(input logic [6:0] op, input int fw, input int mw,
                              input logic tk, input string nm);
        bit to;
        bit trapped;
        int r0;
        logic tk_d;
        r0 = retire_seen;
        trapped = 1'b0;
        hs_phase(P_F, op, fw, {nm, "_fetch"}, to);
        if (to) begin
            trap_phase(2'b10, 4, {nm, "_fetch_timeout_trap"});
            trapped = 1'b1;
        end else begin
            step(1'b0, rbit(), rbit(), op, exp_out(P_D, op, 1'b0, 1'b0, 2'b00), {nm, "_decode"});
            if (!is_legal(op)) begin
                trap_phase(2'b01, 3, {nm, "_illegal_trap"});
                trapped = 1'b1;
            end else begin
                tk_d = (op == OP_BR) ? tk : rbit();
                step(1'b0, rbit(), tk_d, rop(), exp_out(P_E, op, 1'b0, tk_d, 2'b00), {nm, "_exec"});
                if (op == OP_LW || op == OP_SW) begin
                    hs_phase(P_M, op, mw, {nm, "_mem"}, to);
                    if (to) begin
                        trap_phase(2'b10, 4, {nm, "_mem_timeout_trap"});
                        trapped = 1'b1;
                    end
                end
                if (!trapped && (op == OP_LW || op == OP_R || op == OP_IMM))
                    step(1'b0, rbit(), rbit(), rop(), exp_out(P_W, op, 1'b0, 1'b0, 2'b00), {nm, "_wb"});
            end
        end
        n_checks++;
        if ((retire_seen - r0) != (trapped ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s_retire_count: got %0d expected %0d", nm, retire_seen - r0, trapped ? 0 : 1);
        end
        $display("instr %s op=%02h fetch_waits=%0d mem_waits=%0d taken=%0d trapped=%0d",
                 nm, op, fw, mw, tk, trapped);
        if (trapped) test_reset();
    endtask

    task automatic test_directed();
        test_instr(OP_R,    0, 0, 1'b0, "rtype");
        test_instr(OP_LW,   2, 0, 1'b0, "lw_fetch2");
        test_instr(OP_BR,   0, 0, 1'b1, "br_taken");
        test_instr(OP_BR,   0, 0, 1'b0, "br_not_taken");
        test_instr(OP_JAL,  0, 0, 1'b0, "jal");
        test_instr(OP_JALR, 0, 0, 1'b0, "jalr");
        test_instr(OP_IMM,  1, 0, 1'b0, "imm");
        test_instr(OP_SW,   0, 1, 1'b0, "sw");
    endtask

    task automatic test_illegal();
        test_instr(7'h7F, 0, 0, 1'b0, "illegal_7f");
        trap_phase(2'b00, 0, "unused");
    endtask

    // An illegal opcode stays trapped with every enable low for a long stretch.
    task automatic test_trap_sticky();
        step(1'b0, 1'b1, rbit(), rop(), exp_out(P_F, 7'h00, 1'b1, 1'b0, 2'b00), "sticky_fetch");
        step(1'b0, rbit(), rbit(), 7'h7F, exp_out(P_D, 7'h7F, 1'b0, 1'b0, 2'b00), "sticky_decode");
        trap_phase(2'b01, 20, "sticky_trap");
        $display("trap held 20 cycles with cause 01");
        test_reset();
        test_instr(OP_R, 0, 0, 1'b0, "after_trap_rtype");
    endtask

    task automatic test_timeout();
        test_instr(OP_SW, 0, 4, 1'b0, "sw_mem_timeout");
        test_instr(OP_SW, 0, 3, 1'b0, "sw_ready_on_limit");
        test_instr(OP_LW, 3, 3, 1'b0, "lw_both_limit");
        test_instr(OP_R,  4, 0, 1'b0, "fetch_timeout");
    endtask

    // Reset while MEM is waiting on an SW: the request and the write drop at once, and the next instruction fetches cleanly.
    task automatic test_reset_mid_mem();
        step(1'b0, 1'b1, rbit(), rop(), exp_out(P_F, OP_SW, 1'b1, 1'b0, 2'b00), "rmm_fetch");
        step(1'b0, rbit(), rbit(), OP_SW, exp_out(P_D, OP_SW, 1'b0, 1'b0, 2'b00), "rmm_decode");
        step(1'b0, rbit(), rbit(), rop(), exp_out(P_E, OP_SW, 1'b0, 1'b0, 2'b00), "rmm_exec");
        step(1'b0, 1'b0, rbit(), rop(), exp_out(P_M, OP_SW, 1'b0, 1'b0, 2'b00), "rmm_mem_wait");
        step(1'b1, 1'b1, rbit(), rop(), '0, "rmm_reset_drop");
        $display("reset during SW mem wait");
        test_instr(OP_R, 0, 0, 1'b0, "rmm_restart");
    endtask

    task automatic test_back_to_back_random();
        logic [6:0] legal [7];
        logic [6:0] op;
        legal = '{OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR};
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 3) == 0) ? rop() : legal[$urandom_range(0, 6)];
            test_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rbit(), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_trap_sticky();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
